// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU issue sequencer: FSM states,
// decoded-instruction record, ALU op codes and F register bit positions.
package alu_seq_pkg;

    // Register index of the accumulator and the operand index meaning (HL).
    localparam logic [2:0] A_IDX_DEFAULT      = 3'd7;
    localparam logic [2:0] HL_IND_IDX_DEFAULT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MEM_RD = 3'd1,
        S_ISSUE  = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_MEM_WR = 3'd5
    } state_t;

    typedef enum logic {
        DST_REG = 1'b0,
        DST_MEM = 1'b1
    } dst_class_t;

    // Main ALU group (ext=0, misc=0)
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADC  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SBC  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_CP   = 3'd7;
    // CB shift/rotate group (ext=1, misc=0)
    localparam logic [2:0] OP_RLC  = 3'd0;
    localparam logic [2:0] OP_RRC  = 3'd1;
    localparam logic [2:0] OP_RL   = 3'd2;
    localparam logic [2:0] OP_RR   = 3'd3;
    localparam logic [2:0] OP_SLA  = 3'd4;
    localparam logic [2:0] OP_SRA  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_SRL  = 3'd7;
    // Accumulator misc group (ext=0, misc=1)
    localparam logic [2:0] OP_RLCA = 3'd0;
    localparam logic [2:0] OP_RRCA = 3'd1;
    localparam logic [2:0] OP_RLA  = 3'd2;
    localparam logic [2:0] OP_RRA  = 3'd3;
    localparam logic [2:0] OP_DAA  = 3'd4;
    localparam logic [2:0] OP_CPL  = 3'd5;
    localparam logic [2:0] OP_SCF  = 3'd6;
    localparam logic [2:0] OP_CCF  = 3'd7;
    // Bit group (ext=1, misc=1) and inc/dec (incdec=1, misc=1)
    localparam logic [2:0] OP_BIT  = 3'd1;
    localparam logic [2:0] OP_RES  = 3'd2;
    localparam logic [2:0] OP_SET  = 3'd3;
    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_DEC  = 3'd1;

    // F register bit positions; the low nibble of F always reads as zero.
    localparam int F_Z = 7;
    localparam int F_N = 6;
    localparam int F_H = 5;
    localparam int F_C = 4;
    localparam logic [7:0] F_MASK = 8'((1 << F_Z) | (1 << F_N) | (1 << F_H) | (1 << F_C));

    // Everything the sequencer needs to remember about the accepted opcode.
    typedef struct packed {
        logic [2:0] op;
        logic       ext;
        logic       misc;
        logic       incdec;
        logic [2:0] bit_index;
        logic [2:0] src_idx;
        logic [2:0] dst_idx;
        dst_class_t dst_class;
        logic       wr_res;
        logic       wr_flags;
    } dec_t;

    // ALU t_cycle as a function of sequencer state.
    function automatic logic [1:0] t_cycle_of(state_t s);
        logic [1:0] t;
        t = 2'b00;
        case (s)
            S_EXEC:   t = 2'b01;
            S_WB:     t = 2'b10;
            S_MEM_WR: t = 2'b11;
            default:  t = 2'b00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: maps a base-page or CB-page opcode onto the
// ALU control fields, operand/destination indices and writeback masks.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter logic [2:0] A_IDX      = A_IDX_DEFAULT,
    parameter logic [2:0] HL_IND_IDX = HL_IND_IDX_DEFAULT
) (
    input  logic [7:0] opcode,
    input  logic       cb,
    output logic [2:0] op,
    output logic       ext,
    output logic       misc,
    output logic       incdec,
    output logic [2:0] bit_index,
    output logic [2:0] src_idx,
    output logic [2:0] dst_idx,
    output logic       src_mem,
    output logic       dst_mem,
    output logic       wr_res,
    output logic       wr_flags,
    output logic       illegal
);

    logic [1:0] grp;
    logic [2:0] mid;
    logic [2:0] low;

    assign grp = opcode[7:6];
    assign mid = opcode[5:3];
    assign low = opcode[2:0];

    // Field decode; every output defaulted first so no latches form.
    always_comb begin
        op        = 3'd0;
        ext       = 1'b0;
        misc      = 1'b0;
        incdec    = 1'b0;
        bit_index = 3'd0;
        src_idx   = low;
        dst_idx   = A_IDX;
        wr_res    = 1'b1;
        wr_flags  = 1'b1;
        illegal   = 1'b0;

        if (cb) begin
            ext     = 1'b1;
            dst_idx = low;
            case (grp)
                2'b00: op = mid;
                2'b01: begin
                    misc      = 1'b1;
                    op        = OP_BIT;
                    bit_index = mid;
                    wr_res    = 1'b0;
                end
                2'b10: begin
                    misc      = 1'b1;
                    op        = OP_RES;
                    bit_index = mid;
                    wr_flags  = 1'b0;
                end
                default: begin
                    misc      = 1'b1;
                    op        = OP_SET;
                    bit_index = mid;
                    wr_flags  = 1'b0;
                end
            endcase
        end else if (grp == 2'b10) begin
            op = mid;
            // CP only compares; A is left untouched.
            if (mid == OP_CP) wr_res = 1'b0;
        end else if (grp == 2'b00) begin
            case (low)
                3'b111: begin
                    misc    = 1'b1;
                    op      = mid;
                    src_idx = A_IDX;
                    // SCF/CCF only touch the carry flag.
                    if (mid == OP_SCF || mid == OP_CCF) wr_res = 1'b0;
                end
                3'b100: begin
                    misc    = 1'b1;
                    incdec  = 1'b1;
                    op      = OP_INC;
                    src_idx = mid;
                    dst_idx = mid;
                end
                3'b101: begin
                    misc    = 1'b1;
                    incdec  = 1'b1;
                    op      = OP_DEC;
                    src_idx = mid;
                    dst_idx = mid;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            illegal = 1'b1;
        end

        if (illegal) begin
            wr_res   = 1'b0;
            wr_flags = 1'b0;
        end
    end

    assign src_mem = (src_idx == HL_IND_IDX) && !illegal;
    assign dst_mem = (dst_idx == HL_IND_IDX);

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 8-bit ALU. Accepts one opcode at a time,
// optionally fetches an (HL) operand, steps the ALU through its t-cycles and
// writes the result and flags back to the register file, F or memory.
//
// Handshake: an opcode transfers on a cycle where instr_valid and
// instr_ready are both high; instr_ready is high only while idle. Memory
// requests are held high until the matching ack is seen high on a clock
// edge; acks outside an outstanding request have no effect.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [2:0] A_IDX      = A_IDX_DEFAULT,
    parameter logic [2:0] HL_IND_IDX = HL_IND_IDX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr_opcode,
    input  logic       instr_cb,
    output logic       done,
    output logic       illegal,
    output logic [2:0] alu_op,
    output logic       alu_ext,
    output logic       alu_misc,
    output logic       alu_incdec,
    output logic       alu_src_sel,
    output logic [2:0] alu_bit_index,
    output logic [1:0] alu_t_cycle,
    output logic       alu_begin,
    input  logic [7:0] alu_res,
    input  logic [7:0] alu_flags,
    input  logic       alu_wr_en_flags,
    output logic [2:0] reg_rd_idx,
    output logic       reg_wr_en,
    output logic [2:0] reg_wr_idx,
    output logic [7:0] reg_wr_data,
    output logic       flags_wr_en,
    output logic [7:0] flags_wr_data,
    output logic       mem_rd_req,
    input  logic       mem_rd_ack,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] mem_data,
    output logic       mem_wr_req,
    input  logic       mem_wr_ack,
    output logic [7:0] mem_wr_data
);

    // FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_next;

    dec_t   dec_in;
    dec_t   dec_q;
    logic   dec_src_mem;
    logic   dec_dst_mem;
    logic   dec_illegal;

    logic [7:0] res_q;
    logic [7:0] flags_q;
    logic       flags_ok_q;
    logic [7:0] mem_data_q;
    logic       src_sel_q;
    logic       illegal_q;
    logic       done_wr_q;
    logic       accept;
    logic       result_to_mem;

    // The decoder always looks at the live opcode; its output is only
    // captured on the accept cycle.
    alu_seq_decode #(
        .A_IDX      (A_IDX),
        .HL_IND_IDX (HL_IND_IDX)
    ) u_decode (
        .opcode    (instr_opcode),
        .cb        (instr_cb),
        .op        (dec_in.op),
        .ext       (dec_in.ext),
        .misc      (dec_in.misc),
        .incdec    (dec_in.incdec),
        .bit_index (dec_in.bit_index),
        .src_idx   (dec_in.src_idx),
        .dst_idx   (dec_in.dst_idx),
        .src_mem   (dec_src_mem),
        .dst_mem   (dec_dst_mem),
        .wr_res    (dec_in.wr_res),
        .wr_flags  (dec_in.wr_flags),
        .illegal   (dec_illegal)
    );

    assign dec_in.dst_class = dec_dst_mem ? DST_MEM : DST_REG;
    assign accept           = (state == S_IDLE) && instr_valid;
    assign result_to_mem    = dec_q.wr_res && (dec_q.dst_class == DST_MEM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state and per-state control strobes.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        alu_begin   = 1'b0;
        reg_wr_en   = 1'b0;
        flags_wr_en = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        done        = done_wr_q;

        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && !dec_illegal)
                    state_next = dec_src_mem ? S_MEM_RD : S_ISSUE;
            end
            S_MEM_RD: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) state_next = S_ISSUE;
            end
            S_ISSUE: state_next = S_EXEC;
            S_EXEC: begin
                alu_begin  = 1'b1;
                state_next = S_WB;
            end
            S_WB: begin
                flags_wr_en = dec_q.wr_flags && flags_ok_q;
                reg_wr_en   = dec_q.wr_res && !result_to_mem;
                if (result_to_mem) begin
                    state_next = S_MEM_WR;
                end else begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_MEM_WR: begin
                mem_wr_req = 1'b1;
                if (mem_wr_ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Capture the decoded instruction and the (HL) operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q      <= '0;
            src_sel_q  <= 1'b0;
            mem_data_q <= 8'h00;
        end else begin
            if (accept && !dec_illegal) begin
                dec_q     <= dec_in;
                src_sel_q <= 1'b0;
            end
            if (state == S_MEM_RD && mem_rd_ack) begin
                mem_data_q <= mem_rd_data;
                src_sel_q  <= 1'b1;
            end
        end
    end

    // Register ALU result and flags at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q      <= 8'h00;
            flags_q    <= 8'h00;
            flags_ok_q <= 1'b0;
        end else if (state == S_EXEC) begin
            res_q      <= alu_res;
            flags_ok_q <= alu_wr_en_flags;
            if (alu_wr_en_flags) flags_q <= alu_flags & F_MASK;
        end
    end

    // One-cycle illegal pulse, and done one cycle after the memory write ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
            done_wr_q <= 1'b0;
        end else begin
            illegal_q <= accept && dec_illegal;
            done_wr_q <= (state == S_MEM_WR) && mem_wr_ack;
        end
    end

    assign illegal       = illegal_q;
    assign alu_op        = dec_q.op;
    assign alu_ext       = dec_q.ext;
    assign alu_misc      = dec_q.misc;
    assign alu_incdec    = dec_q.incdec;
    assign alu_bit_index = dec_q.bit_index;
    assign alu_src_sel   = src_sel_q;
    assign alu_t_cycle   = t_cycle_of(state);
    assign reg_rd_idx    = dec_q.src_idx;
    assign reg_wr_idx    = dec_q.dst_idx;
    assign reg_wr_data   = res_q;
    assign flags_wr_data = flags_q;
    assign mem_data      = mem_data_q;
    assign mem_wr_data   = res_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. The bench plays the ALU and the memory bus,
// presents opcodes, records what the sequencer does cycle by cycle and
// compares that against a reference derived from the opcode tables.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic       instr_cb;
    logic       done;
    logic       illegal;
    logic [2:0] alu_op;
    logic       alu_ext;
    logic       alu_misc;
    logic       alu_incdec;
    logic       alu_src_sel;
    logic [2:0] alu_bit_index;
    logic [1:0] alu_t_cycle;
    logic       alu_begin;
    logic [7:0] alu_res;
    logic [7:0] alu_flags;
    logic       alu_wr_en_flags;
    logic [2:0] reg_rd_idx;
    logic       reg_wr_en;
    logic [2:0] reg_wr_idx;
    logic [7:0] reg_wr_data;
    logic       flags_wr_en;
    logic [7:0] flags_wr_data;
    logic       mem_rd_req;
    logic       mem_rd_ack;
    logic [7:0] mem_rd_data;
    logic [7:0] mem_data;
    logic       mem_wr_req;
    logic       mem_wr_ack;
    logic [7:0] mem_wr_data;

    int errors = 0;
    int checks = 0;

    // ALU stand-in: the intended answer is only visible while alu_begin is
    // high; every other cycle it shows noise.
    logic [7:0] stub_res, stub_flags, junk_res, junk_flags;
    logic       stub_fvalid, junk_fvalid;
    assign alu_res         = alu_begin ? stub_res    : junk_res;
    assign alu_flags       = alu_begin ? stub_flags  : junk_flags;
    assign alu_wr_en_flags = alu_begin ? stub_fvalid : junk_fvalid;

    // Observations of one instruction (cycle 0 = accept cycle).
    int         obs_begin_cnt, obs_begin_cyc, obs_done_cnt, obs_done_cyc;
    int         obs_ill_cnt, obs_ill_cyc, obs_regwr_cnt, obs_flagwr_cnt;
    int         obs_memwr_cnt, obs_memwr_cyc, obs_rdreq_cnt, obs_wb_cyc;
    int         obs_overlap, obs_dbl_begin;
    bit         obs_timeout;
    logic [2:0] obs_op, obs_bit, obs_rd_idx, obs_wr_idx;
    logic       obs_ext, obs_misc, obs_incdec, obs_src;
    logic [7:0] obs_mem_data, obs_reg_data, obs_flag_data, obs_memwr_data;

    alu_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_opcode    (instr_opcode),
        .instr_cb        (instr_cb),
        .done            (done),
        .illegal         (illegal),
        .alu_op          (alu_op),
        .alu_ext         (alu_ext),
        .alu_misc        (alu_misc),
        .alu_incdec      (alu_incdec),
        .alu_src_sel     (alu_src_sel),
        .alu_bit_index   (alu_bit_index),
        .alu_t_cycle     (alu_t_cycle),
        .alu_begin       (alu_begin),
        .alu_res         (alu_res),
        .alu_flags       (alu_flags),
        .alu_wr_en_flags (alu_wr_en_flags),
        .reg_rd_idx      (reg_rd_idx),
        .reg_wr_en       (reg_wr_en),
        .reg_wr_idx      (reg_wr_idx),
        .reg_wr_data     (reg_wr_data),
        .flags_wr_en     (flags_wr_en),
        .flags_wr_data   (flags_wr_data),
        .mem_rd_req      (mem_rd_req),
        .mem_rd_ack      (mem_rd_ack),
        .mem_rd_data     (mem_rd_data),
        .mem_data        (mem_data),
        .mem_wr_req      (mem_wr_req),
        .mem_wr_ack      (mem_wr_ack),
        .mem_wr_data     (mem_wr_data)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference decode, written straight from the opcode tables.
    task automatic model(input logic [7:0] opc, input logic is_cb, output bit legal,
                         output int op, output bit ext, output bit misc, output bit incdec,
                         output int bidx, output int src, output int dst,
                         output bit wr_res, output bit wr_flags);
        int grp, mid, low;
        grp = int'(opc) / 64;
        mid = (int'(opc) / 8) % 8;
        low = int'(opc) % 8;
        legal = 1; op = 0; ext = 0; misc = 0; incdec = 0; bidx = 0;
        src = low; dst = 7; wr_res = 1; wr_flags = 1;
        if (is_cb) begin
            ext = 1; dst = low;
            if (grp == 0) op = mid;
            else begin
                misc = 1; bidx = mid; op = grp;          // BIT=1, RES=2, SET=3
                wr_res = (grp != 1); wr_flags = (grp == 1);
            end
        end else if (opc >= 8'h80 && opc <= 8'hBF) begin
            op = mid; wr_res = (mid != 7);               // CP keeps A
        end else if (opc < 8'h40 && low == 7) begin
            misc = 1; op = mid; src = 7; wr_res = (mid < 6); // SCF/CCF flags only
        end else if (opc < 8'h40 && (low == 4 || low == 5)) begin
            misc = 1; incdec = 1; op = low - 4; src = mid; dst = mid;
        end else begin
            legal = 0;
        end
    endtask

    // Driver/monitor: present one opcode (caller sits at a negedge), then
    // answer memory requests and record the sequencer's activity.
    task automatic issue(input logic [7:0] opc, input logic is_cb, input int rd_wait,
                         input int wr_wait, input logic [7:0] mbyte);
        int  guard, rd_k, wr_k;
        bit  fin, prev_begin;
        obs_begin_cnt = 0; obs_begin_cyc = -1; obs_done_cnt = 0; obs_done_cyc = -1;
        obs_ill_cnt = 0; obs_ill_cyc = -1; obs_regwr_cnt = 0; obs_flagwr_cnt = 0;
        obs_memwr_cnt = 0; obs_memwr_cyc = -1; obs_rdreq_cnt = 0; obs_wb_cyc = -1;
        obs_overlap = 0; obs_dbl_begin = 0; obs_timeout = 0;
        guard = 0;
        while (!instr_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            obs_timeout = 1;
            return;
        end
        instr_valid = 1'b1; instr_opcode = opc; instr_cb = is_cb;
        rd_k = 0; wr_k = 0; fin = 0; prev_begin = 0;
        for (int c = 1; c <= 80 && !fin; c++) begin
            @(negedge clk);
            instr_valid = 1'b0; instr_opcode = 8'($urandom); instr_cb = 1'($urandom);
            junk_res = 8'($urandom); junk_flags = 8'($urandom); junk_fvalid = 1'($urandom);
            if (mem_rd_req && mem_wr_req) obs_overlap++;
            if (alu_begin) begin
                if (prev_begin) obs_dbl_begin++;
                obs_begin_cnt++; obs_begin_cyc = c;
                obs_op = alu_op; obs_ext = alu_ext; obs_misc = alu_misc;
                obs_incdec = alu_incdec; obs_bit = alu_bit_index; obs_src = alu_src_sel;
                obs_rd_idx = reg_rd_idx; obs_mem_data = mem_data;
            end
            prev_begin = alu_begin;
            if (reg_wr_en) begin
                obs_regwr_cnt++; obs_wr_idx = reg_wr_idx; obs_reg_data = reg_wr_data; obs_wb_cyc = c;
            end
            if (flags_wr_en) begin
                obs_flagwr_cnt++; obs_flag_data = flags_wr_data; obs_wb_cyc = c;
            end
            if (illegal) begin obs_ill_cnt++; obs_ill_cyc = c; end
            if (done) begin obs_done_cnt++; obs_done_cyc = c; end
            if (mem_rd_req) begin
                obs_rdreq_cnt++; rd_k++;
                mem_rd_ack  = (rd_k == rd_wait + 1);
                mem_rd_data = mem_rd_ack ? mbyte : 8'($urandom);
            end else begin
                mem_rd_ack  = ($urandom_range(0, 3) == 0);
                mem_rd_data = 8'($urandom);
            end
            if (mem_wr_req) begin
                wr_k++;
                mem_wr_ack = (wr_k == wr_wait + 1);
                if (mem_wr_ack) begin
                    obs_memwr_cnt++; obs_memwr_data = mem_wr_data; obs_memwr_cyc = c;
                end
            end else begin
                mem_wr_ack = ($urandom_range(0, 3) == 0);
            end
            if (obs_done_cnt > 0 || (obs_ill_cnt > 0 && c >= 4)) fin = 1;
        end
        if (!fin) obs_timeout = 1;
        mem_rd_ack = 1'b0;
        mem_wr_ack = 1'b0;
    endtask

    task automatic set_alu(input logic [7:0] r, input logic [7:0] f, input logic fv);
        stub_res = r; stub_flags = f; stub_fvalid = fv;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr_opcode = 8'h00; instr_cb = 1'b0;
        mem_rd_ack = 1'b0; mem_wr_ack = 1'b0; mem_rd_data = 8'h00;
        junk_res = 8'h00; junk_flags = 8'h00; junk_fvalid = 1'b0;
        set_alu(8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        checks++;
        if ({done, illegal, alu_op, alu_ext, alu_misc, alu_incdec, alu_src_sel, alu_bit_index,
             alu_t_cycle, alu_begin, reg_rd_idx, reg_wr_en, reg_wr_idx, reg_wr_data,
             flags_wr_en, flags_wr_data, mem_rd_req, mem_data, mem_wr_req, mem_wr_data} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero, want all 0");
        end
        rst = 1'b0;
    endtask

    // ADD A,B with A=0x3A, B=0xC6: the ALU answers 0x00 with Z,H,C set.
    task automatic test_add_a_b();
        set_alu(8'h00, 8'hB0, 1'b1);
        issue(8'h80, 1'b0, 0, 0, 8'h00);
        checks++;
        if (obs_begin_cnt != 1 || obs_begin_cyc != 2) begin
            errors++; $display("FAIL add_begin: got cnt=%0d cyc=%0d want 1 at 2", obs_begin_cnt, obs_begin_cyc);
        end
        checks++;
        if (obs_regwr_cnt != 1 || obs_wr_idx !== 3'd7 || obs_reg_data !== 8'h00 || obs_wb_cyc != 3) begin
            errors++; $display("FAIL add_regwr: got cnt=%0d idx=%0d data=%h cyc=%0d want 1 7 00 3",
                               obs_regwr_cnt, obs_wr_idx, obs_reg_data, obs_wb_cyc);
        end
        checks++;
        if (obs_flagwr_cnt != 1 || obs_flag_data !== 8'hB0) begin
            errors++; $display("FAIL add_flags: got cnt=%0d data=%h want 1 b0", obs_flagwr_cnt, obs_flag_data);
        end
        checks++;
        if (obs_done_cnt != 1 || obs_done_cyc != 3) begin
            errors++; $display("FAIL add_done: got cnt=%0d cyc=%0d want 1 at 3", obs_done_cnt, obs_done_cyc);
        end
    endtask

    task automatic test_cp();
        set_alu(8'h55, 8'hC0, 1'b1);
        issue(8'hB8, 1'b0, 0, 0, 8'h00);
        checks++;
        if (obs_flagwr_cnt != 1 || obs_regwr_cnt != 0 || obs_flag_data !== 8'hC0) begin
            errors++; $display("FAIL cp_writes: got flags=%0d reg=%0d fdata=%h want 1 0 c0",
                               obs_flagwr_cnt, obs_regwr_cnt, obs_flag_data);
        end
    endtask

    // BIT 7,H with H=0x80: bit set, so Z=0, H=1 (plus carry held).
    task automatic test_bit_h();
        set_alu(8'h80, 8'h3F, 1'b1);
        issue(8'h7C, 1'b1, 0, 0, 8'h00);
        checks++;
        if (obs_misc !== 1'b1 || obs_ext !== 1'b1 || obs_bit !== 3'd7 || obs_op !== 3'd1 || obs_rd_idx !== 3'd4) begin
            errors++; $display("FAIL bit_h_fields: got misc=%b ext=%b bit=%0d op=%0d rd=%0d want 1 1 7 1 4",
                               obs_misc, obs_ext, obs_bit, obs_op, obs_rd_idx);
        end
        checks++;
        if (obs_flag_data !== 8'h30 || obs_regwr_cnt != 0 || obs_memwr_cnt != 0) begin
            errors++; $display("FAIL bit_h_wb: got flags=%h reg=%0d mem=%0d want 30 0 0",
                               obs_flag_data, obs_regwr_cnt, obs_memwr_cnt);
        end
    endtask

    // BIT 0,(HL) with (HL)=0xFE, ack on the third request cycle.
    task automatic test_bit_hl();
        set_alu(8'hFE, 8'hA0, 1'b1);
        issue(8'h46, 1'b1, 2, 0, 8'hFE);
        checks++;
        if (obs_src !== 1'b1 || obs_mem_data !== 8'hFE || obs_rdreq_cnt != 3) begin
            errors++; $display("FAIL bit_hl_read: got src=%b mem=%h reqcyc=%0d want 1 fe 3",
                               obs_src, obs_mem_data, obs_rdreq_cnt);
        end
        checks++;
        if (obs_flag_data[7] !== 1'b1 || obs_memwr_cnt != 0 || obs_done_cyc != 6) begin
            errors++; $display("FAIL bit_hl_wb: got z=%b memwr=%0d done=%0d want 1 0 6",
                               obs_flag_data[7], obs_memwr_cnt, obs_done_cyc);
        end
    endtask

    task automatic test_set_hl();
        set_alu(8'h11, 8'hF0, 1'b1);
        issue(8'hC6, 1'b1, 1, 2, 8'h10);
        checks++;
        if (obs_memwr_cnt != 1 || obs_memwr_data !== 8'h11 || obs_flagwr_cnt != 0 || obs_regwr_cnt != 0) begin
            errors++; $display("FAIL set_hl_wb: got memwr=%0d data=%h flags=%0d reg=%0d want 1 11 0 0",
                               obs_memwr_cnt, obs_memwr_data, obs_flagwr_cnt, obs_regwr_cnt);
        end
        checks++;
        if (obs_done_cyc != obs_memwr_cyc + 1 || obs_done_cnt != 1) begin
            errors++; $display("FAIL set_hl_done: got done=%0d ack=%0d want done=ack+1",
                               obs_done_cyc, obs_memwr_cyc);
        end
    endtask

    // INC (HL) with (HL)=0xFF wraps to 0x00 with Z and H set.
    task automatic test_inc_hl();
        set_alu(8'h00, 8'hA0, 1'b1);
        issue(8'h34, 1'b0, 0, 0, 8'hFF);
        checks++;
        if (obs_incdec !== 1'b1 || obs_misc !== 1'b1 || obs_op !== 3'd0 || obs_mem_data !== 8'hFF) begin
            errors++; $display("FAIL inc_hl_fields: got incdec=%b misc=%b op=%0d mem=%h want 1 1 0 ff",
                               obs_incdec, obs_misc, obs_op, obs_mem_data);
        end
        checks++;
        if (obs_memwr_cnt != 1 || obs_memwr_data !== 8'h00 || obs_flag_data[7] !== 1'b1) begin
            errors++; $display("FAIL inc_hl_wb: got memwr=%0d data=%h z=%b want 1 00 1",
                               obs_memwr_cnt, obs_memwr_data, obs_flag_data[7]);
        end
    endtask

    task automatic test_illegal();
        issue(8'h00, 1'b0, 0, 0, 8'h00);
        checks++;
        if (obs_ill_cnt != 1 || obs_ill_cyc != 1 || obs_done_cnt != 0 || obs_begin_cnt != 0) begin
            errors++; $display("FAIL illegal_00: got ill=%0d at %0d done=%0d begin=%0d want 1 at 1 0 0",
                               obs_ill_cnt, obs_ill_cyc, obs_done_cnt, obs_begin_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        bit seen;
        guard = 0; seen = 0;
        while (!instr_ready && guard < 100) begin guard++; @(negedge clk); end
        instr_valid = 1'b1; instr_opcode = 8'h46; instr_cb = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (mem_rd_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_req: got %b want 1", mem_rd_req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({mem_rd_req, mem_wr_req, done, reg_wr_en, flags_wr_en, alu_begin, instr_ready} !== 7'b0000001) begin
            errors++; $display("FAIL rstmid_after: got rd=%b wr=%b done=%b rw=%b fw=%b beg=%b rdy=%b want 0000001",
                               mem_rd_req, mem_wr_req, done, reg_wr_en, flags_wr_en, alu_begin, instr_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (done || alu_begin || mem_rd_req) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rstmid_quiet: got activity after reset want none");
        end
    endtask

    task automatic test_random();
        bit legal, ext, misc, incdec, wr_res, wr_flags, hl_rd, to_mem, exp_fw;
        int op, bidx, src, dst, rdw, wrw, e_begin, e_done;
        logic [7:0] opc, mb, r, f;
        logic cbv, fv;
        for (int i = 0; i < 200; i++) begin
            opc = 8'($urandom); cbv = 1'($urandom); mb = 8'($urandom);
            r = 8'($urandom); f = 8'($urandom); fv = ($urandom_range(0, 3) != 0);
            rdw = $urandom_range(0, 3); wrw = $urandom_range(0, 3);
            set_alu(r, f, fv);
            issue(opc, cbv, rdw, wrw, mb);
            model(opc, cbv, legal, op, ext, misc, incdec, bidx, src, dst, wr_res, wr_flags);
            checks++;
            if (obs_timeout || obs_overlap != 0 || obs_dbl_begin != 0) begin
                errors++; $display("FAIL rnd_proto #%0d op=%h cb=%b: got timeout=%b overlap=%0d dbl=%0d want 0 0 0",
                                   i, opc, cbv, obs_timeout, obs_overlap, obs_dbl_begin);
            end
            if (!legal) begin
                checks++;
                if (obs_ill_cnt != 1 || obs_done_cnt != 0 || obs_begin_cnt != 0) begin
                    errors++; $display("FAIL rnd_illegal #%0d op=%h cb=%b: got ill=%0d done=%0d beg=%0d want 1 0 0",
                                       i, opc, cbv, obs_ill_cnt, obs_done_cnt, obs_begin_cnt);
                end
                continue;
            end
            hl_rd   = (src == 6);
            to_mem  = wr_res && (dst == 6);
            exp_fw  = wr_flags && fv;
            e_begin = 2 + (hl_rd ? rdw + 1 : 0);
            e_done  = to_mem ? e_begin + 1 + wrw + 2 : e_begin + 1;
            checks++;
            if (obs_ill_cnt != 0 || obs_begin_cnt != 1 || obs_begin_cyc != e_begin) begin
                errors++; $display("FAIL rnd_begin #%0d op=%h cb=%b: got ill=%0d cnt=%0d cyc=%0d want 0 1 %0d",
                                   i, opc, cbv, obs_ill_cnt, obs_begin_cnt, obs_begin_cyc, e_begin);
            end
            checks++;
            if (obs_op !== 3'(op) || obs_ext !== ext || obs_misc !== misc || obs_incdec !== incdec ||
                obs_rd_idx !== 3'(src) || obs_src !== hl_rd || (ext && misc && obs_bit !== 3'(bidx))) begin
                errors++; $display("FAIL rnd_fields #%0d op=%h cb=%b: got %0d/%b/%b/%b/%0d/%b/%0d want %0d/%b/%b/%b/%0d/%b/%0d",
                                   i, opc, cbv, obs_op, obs_ext, obs_misc, obs_incdec, obs_rd_idx, obs_src, obs_bit,
                                   op, ext, misc, incdec, src, hl_rd, bidx);
            end
            checks++;
            if (hl_rd && obs_mem_data !== mb) begin
                errors++; $display("FAIL rnd_memdata #%0d: got %h want %h", i, obs_mem_data, mb);
            end
            checks++;
            if (obs_regwr_cnt != ((wr_res && !to_mem) ? 1 : 0) ||
                (obs_regwr_cnt == 1 && (obs_wr_idx !== 3'(dst) || obs_reg_data !== r))) begin
                errors++; $display("FAIL rnd_regwr #%0d op=%h cb=%b: got cnt=%0d idx=%0d data=%h want res=%b idx=%0d data=%h",
                                   i, opc, cbv, obs_regwr_cnt, obs_wr_idx, obs_reg_data, wr_res && !to_mem, dst, r);
            end
            checks++;
            if (obs_flagwr_cnt != (exp_fw ? 1 : 0) || (exp_fw && obs_flag_data !== (f & 8'hF0))) begin
                errors++; $display("FAIL rnd_flags #%0d op=%h cb=%b: got cnt=%0d data=%h want %b %h",
                                   i, opc, cbv, obs_flagwr_cnt, obs_flag_data, exp_fw, f & 8'hF0);
            end
            checks++;
            if (obs_memwr_cnt != (to_mem ? 1 : 0) || (to_mem && obs_memwr_data !== r)) begin
                errors++; $display("FAIL rnd_memwr #%0d op=%h cb=%b: got cnt=%0d data=%h want %b %h",
                                   i, opc, cbv, obs_memwr_cnt, obs_memwr_data, to_mem, r);
            end
            checks++;
            if (obs_done_cnt != 1 || obs_done_cyc != e_done || obs_rdreq_cnt != (hl_rd ? rdw + 1 : 0)) begin
                errors++; $display("FAIL rnd_timing #%0d op=%h cb=%b: got done=%0d@%0d rdreq=%0d want 1@%0d %0d",
                                   i, opc, cbv, obs_done_cnt, obs_done_cyc, obs_rdreq_cnt, e_done, hl_rd ? rdw + 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_a_b();
        test_cp();
        test_bit_h();
        test_bit_hl();
        test_set_hl();
        test_inc_hl();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue-side controller for the 8-bit ALU. Decodes one accepted opcode, or one CB-prefixed opcode, into the ALU control fields: op, ext, misc, incdec, src_sel and bit_index.
- Steps the ALU through t_cycle and pulses alu_begin. For (HL) operands, fetches the operand from the memory interface first.
- Captures res and flags_res and writes them back to the register file, the flag register, or memory.
- Sits between the instruction decode/fetch stage and the register file / bus unit.

Parameters:
- A_IDX, 7, register index of the accumulator.
- HL_IND_IDX, 6, operand index that selects memory at (HL) instead of a register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  opcode presented
- instr_ready  out  1  sequencer can accept an opcode
- instr_opcode  in  8  opcode byte
- instr_cb  in  1  opcode belongs to the CB extension page
- done  out  1  one-cycle pulse when the instruction retires
- illegal  out  1  one-cycle pulse when an opcode is not supported
- alu_op  out  3  ALU op field
- alu_ext  out  1  ALU ext
- alu_misc  out  1  ALU misc
- alu_incdec  out  1  ALU incdec
- alu_src_sel  out  1  0 = reg_data, 1 = mem_data
- alu_bit_index  out  3  bit number for BIT/RES/SET
- alu_t_cycle  out  2  ALU t_cycle
- alu_begin  out  1  ALU start strobe
- alu_res  in  8  ALU result
- alu_flags  in  8  ALU flags_res
- alu_wr_en_flags  in  1  ALU flag-valid
- reg_rd_idx  out  3  register-file read select for the operand
- reg_wr_en  out  1  register write strobe
- reg_wr_idx  out  3  register write index
- reg_wr_data  out  8  register write data
- flags_wr_en  out  1  F register write strobe
- flags_wr_data  out  8  F write data; bits 3:0 are forced to 0
- mem_rd_req  out  1  (HL) read request, held until ack
- mem_rd_ack  in  1  read complete; mem_rd_data valid this cycle
- mem_rd_data  in  8  read data, registered into the ALU mem_data
- mem_data  out  8  latched memory operand driven to the ALU
- mem_wr_req  out  1  (HL) write request, held until ack
- mem_wr_ack  in  1  write complete
- mem_wr_data  out  8  write data

Behaviour:
- Reset values: every output is 0, except instr_ready, which is 1. The state is IDLE. Reset in any state aborts the instruction: no write strobe, no done, and any pending mem request drops on the next cycle.
- States: IDLE, MEM_RD, ISSUE, EXEC, WB, MEM_WR.
- IDLE:
  - instr_ready=1 only in IDLE.
  - On instr_valid, latch the opcode and decode it.
  - If the operand index equals HL_IND_IDX and the instruction reads an operand, go to MEM_RD. Otherwise go to ISSUE.
  - An unsupported opcode pulses illegal the next cycle and returns to IDLE without done.
- Decode, non-CB:
  - 10ooorrr (0x80–0xBF): op=ooo, ext=0, misc=0, incdec=0, operand=rrr, destination A.
  - 00ooo111 (0x07–0x3F, step 8): misc=1, op=ooo, operand A, destination A.
  - 00rrr100 is INC: incdec=1, misc=1, op=000, operand and destination rrr.
  - 00rrr101 is DEC: same as INC but op=001.
  - Every other non-CB opcode is illegal.
- Decode, CB page:
  - 00ooorrr: ext=1, misc=0, op=ooo.
  - 01bbbrrr is BIT: ext=1, misc=1, op=001, bit_index=bbb.
  - 10bbbrrr is RES: same but op=010.
  - 11bbbrrr is SET: same but op=011.
- Writeback suppression:
  - CP, BIT, SCF and CCF write flags only.
  - RES and SET write the result only; flags_wr_en=0.
  - All other instructions write both result and flags.
- MEM_RD: hold mem_rd_req until mem_rd_ack, latch mem_rd_data into mem_data, set src_sel=1, then go to ISSUE. alu_t_cycle holds 00 while waiting, with no timeout.
- ISSUE (t=00): ALU fields and reg_rd_idx are stable. ALU flags_res reloads from flags_in.
- EXEC (t=01): alu_begin=1 for exactly this cycle. At the end of EXEC, register alu_res, and register alu_flags if alu_wr_en_flags=1. If alu_wr_en_flags=0, suppress the flag write.
- WB (t=10): one-cycle strobes reg_wr_en and/or flags_wr_en.
  - If the destination is HL_IND_IDX, reg_wr_en stays 0 and the state goes to MEM_WR.
  - Otherwise done=1 and the state returns to IDLE.
- MEM_WR (t=11): hold mem_wr_req with mem_wr_data=result until mem_wr_ack, then pulse done and go to IDLE.
- Latency for a register operand: accept at edge N, ISSUE N+1, EXEC N+2, WB/done N+3, instr_ready high again at N+4. An (HL) operand adds 1+wait cycles per memory access.
- Invariants: mem_rd_req and mem_wr_req are never high together. An ack arriving outside its request is ignored. alu_begin is never high for two consecutive cycles.

Decomposition:
- Package alu_seq_pkg holds:
  - the state encoding;
  - the ALU op localparams (ADD…CP, RLC…SRL, RLCA…CCF, BIT/RES/SET/INC/DEC);
  - F bit indices: Z=7, N=6, H=5, C=4.
- Sub-module alu_seq_decode is pure combinational. It takes opcode and cb and produces the ALU fields, operand index, destination class, write masks and illegal.

Test Plan:
- ADD A,B (0x80), A=0x3A, B=0xC6 through the real ALU -> alu_begin a single pulse at N+2; WB at N+3 with reg_wr_idx=7, data 0x00, flags 0xB0; done at N+3.
- CP B (0xB8) -> flags_wr_en=1, reg_wr_en=0.
- CB 0x7C, BIT 7,H, with H=0x80 -> alu_misc=1, alu_ext=1, bit_index=7; flags Z=0, H=1; no reg write.
- CB 0x46, BIT 0,(HL), mem_rd_data=0xFE, ack after 3 cycles -> src_sel=1; Z=1; no mem_wr_req; done N+6.
- CB 0xC6, SET 0,(HL), data 0x10 -> mem_wr_data=0x11; flags_wr_en=0; done one cycle after mem_wr_ack.
- INC (HL) (0x34), data 0xFF -> mem_wr 0x00, Z=1.
- Opcode 0x00 -> illegal pulse, no done.
- rst asserted during MEM_RD -> next cycle all requests 0, state IDLE, no done.
